mips_run_monitor: RTL and testbench

Synthesizable run controller and checker for the single-cycle MIPS core (TOP_level). It sequences the core's reset, counts execution cycles and observes the core's data-memory write bus (MemWrite, ALUresult as address, WriteDataMem). It declares PASS, FAIL or TIMEOUT when the program writes its completion word to a configurable mailbox address. It replaces fixed-delay stimulus: the same block drives simulation benches and FPGA bring-up, with the verdict on LEDs.

---
 rtl/mips_run_monitor_pkg.sv | 17 +
 rtl/mips_run_monitor_sat_counter.sv | 19 +
 rtl/mips_run_monitor.sv | 120 ++++++++++++
 tb/tb_mips_run_monitor.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_run_monitor_pkg.sv
// Shared definitions for the MIPS run monitor: run-state encoding and
// default mailbox/verdict constants.
package mips_tb_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [31:0] MAILBOX_ADDR_DEF = 32'h0000_0054;
    localparam logic [31:0] PASS_VALUE_DEF   = 32'h0000_0007;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } run_state_t;

endpackage

// File: rtl/mips_run_monitor_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller for the single-cycle MIPS core: sequences core reset, counts
// RUN cycles and data writes, and latches PASS/FAIL/TIMEOUT on a mailbox write.
module mips_run_monitor #(
    parameter int unsigned          DATA_W       = mips_tb_pkg::DATA_W,
    parameter int unsigned          CNT_W        = 24,
    parameter int unsigned          RST_CYCLES   = 4,
    parameter int unsigned          MAX_CYCLES   = 10000,
    parameter logic [DATA_W-1:0]    MAILBOX_ADDR = DATA_W'(mips_tb_pkg::MAILBOX_ADDR_DEF),
    parameter logic [DATA_W-1:0]    PASS_VALUE   = DATA_W'(mips_tb_pkg::PASS_VALUE_DEF)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] ALUresult,
    input  logic [DATA_W-1:0] WriteDataMem,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  write_count,
    output logic [DATA_W-1:0] last_addr,
    output logic [DATA_W-1:0] last_data
);

    import mips_tb_pkg::*;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MAX_CYCLES - 1);

    run_state_t       state;
    logic [CNT_W-1:0] hold_q;
    logic             arm;
    logic             clr;
    logic             in_run;
    logic             hit;

    always_comb begin
        arm    = start && ((state == S_IDLE) || (state == S_DONE));
        clr    = reset || arm;
        in_run = (state == S_RUN);
        hit    = MemWrite && (ALUresult == MAILBOX_ADDR);
    end

    // Hold counter counts up from 0 to RST_CYCLES-1, equivalent to a load-and-decrement.
    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk (CLK),
        .clr (clr),
        .en  (state == S_HOLD),
        .q   (hold_q)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (CLK),
        .clr (clr),
        .en  (in_run),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_write_cnt (
        .clk (CLK),
        .clr (clr),
        .en  (in_run && MemWrite),
        .q   (write_count)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_HOLD;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        last_addr  <= '0;
                        last_data  <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (MemWrite) begin
                        last_addr <= ALUresult;
                        last_data <= WriteDataMem;
                    end
                    // A mailbox hit takes priority over the final timeout cycle.
                    if (hit || (cycle_count == TMO_LAST)) begin
                        state      <= S_DONE;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        pass       <= hit && (WriteDataMem == PASS_VALUE);
                        timeout    <= !hit;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench for mips_run_monitor: randomized write programs checked
// against a per-run prediction of verdict, counts and last write.
module tb_mips_run_monitor;

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 24;
    localparam int unsigned RSTC = 4;
    localparam int unsigned MAXC = 50;
    localparam logic [31:0] MB   = 32'h0000_0054;
    localparam logic [31:0] PV   = 32'h0000_0007;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          MemWrite = 1'b0;
    logic [DW-1:0] ALUresult = '0;
    logic [DW-1:0] WriteDataMem = '0;
    logic          core_reset, running, done, pass, timeout;
    logic [CW-1:0] cycle_count, write_count;
    logic [DW-1:0] last_addr, last_data;

    int n_tests = 0;
    int n_fail  = 0;

    // planned RUN-phase writes, indexed by RUN cycle
    logic        pw [0:63];
    logic [31:0] pa [0:63];
    logic [31:0] pd [0:63];

    always #5 CLK = ~CLK;

    mips_run_monitor #(
        .DATA_W       (DW),
        .CNT_W        (CW),
        .RST_CYCLES   (RSTC),
        .MAX_CYCLES   (MAXC),
        .MAILBOX_ADDR (MB),
        .PASS_VALUE   (PV)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .MemWrite     (MemWrite),
        .ALUresult    (ALUresult),
        .WriteDataMem (WriteDataMem),
        .core_reset   (core_reset),
        .running      (running),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .cycle_count  (cycle_count),
        .write_count  (write_count),
        .last_addr    (last_addr),
        .last_data    (last_data)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] other_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) a = MB ^ (32'h1 << $urandom_range(0, 31));
        else a = $urandom & 32'hFFFF_FFFC;
        if (a == MB) a = a + 32'h4;
        return a;
    endfunction

    task automatic clear_plan();
        for (int r = 0; r < 64; r++) begin
            pw[r] = 1'b0;
            pa[r] = '0;
            pd[r] = '0;
        end
    endtask

    // hit_at < 0 (or beyond the last RUN cycle) means no mailbox write
    task automatic make_random(input int hit_at, input bit good);
        clear_plan();
        for (int r = 0; r < 64; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                pw[r] = 1'b1;
                pa[r] = other_addr();
                pd[r] = $urandom;
            end
        end
        if (hit_at >= 0 && hit_at < 64) begin
            pw[hit_at] = 1'b1;
            pa[hit_at] = MB;
            pd[hit_at] = good ? PV : (PV ^ ($urandom_range(1, 255)));
        end
    endtask

    task automatic run_check(input string tag, input int start_at_run, input bit noise);
        int          e;
        bit          hit;
        bit          exp_pass, exp_to;
        int          exp_cc, exp_wc;
        logic [31:0] exp_la, exp_ld;

        // prediction: first mailbox write within the RUN window ends the run
        e = MAXC - 1;
        hit = 0;
        for (int r = 0; r < MAXC; r++) begin
            if (pw[r] && pa[r] == MB) begin
                e = r;
                hit = 1;
                break;
            end
        end
        exp_pass = hit && (pd[e] == PV);
        exp_to   = !hit;
        exp_cc   = e + 1;
        exp_wc   = 0;
        exp_la   = '0;
        exp_ld   = '0;
        for (int r = 0; r <= e; r++) begin
            if (pw[r]) begin
                exp_wc++;
                exp_la = pa[r];
                exp_ld = pd[r];
            end
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= int'(RSTC); k++) begin
            n_tests++;
            if (core_reset !== 1'b1 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold k=%0d: core_reset=%b running=%b, required 1 0", tag, k, core_reset, running);
            end
            if (k == 1) begin
                n_tests++;
                if (cycle_count !== '0 || write_count !== '0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s arm-clear: cc=%0d wc=%0d done=%b pass=%b to=%b, required all 0",
                             tag, cycle_count, write_count, done, pass, timeout);
                end
            end
            MemWrite     = noise;
            ALUresult    = ($urandom_range(0, 1) == 1) ? MB : other_addr();
            WriteDataMem = PV;
            tick();
        end

        for (int r = 0; r <= e; r++) begin
            n_tests++;
            if (running !== 1'b1 || core_reset !== 1'b0 || cycle_count !== CW'(r) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run r=%0d: running=%b core_reset=%b cc=%0d done=%b, required 1 0 %0d 0",
                         tag, r, running, core_reset, cycle_count, done, r);
            end
            MemWrite     = pw[r];
            ALUresult    = pa[r];
            WriteDataMem = pd[r];
            start        = (r == start_at_run);
            tick();
            start = 1'b0;
        end
        MemWrite = 1'b0;

        n_tests++;
        if (done !== 1'b1 || pass !== exp_pass || timeout !== exp_to || running !== 1'b0 || core_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL %s verdict: done=%b pass=%b to=%b running=%b core_reset=%b, required 1 %b %b 0 1",
                     tag, done, pass, timeout, running, core_reset, exp_pass, exp_to);
        end
        n_tests++;
        if (cycle_count !== CW'(exp_cc) || write_count !== CW'(exp_wc)) begin
            n_fail++;
            $display("FAIL %s counts: cc=%0d wc=%0d, required %0d %0d", tag, cycle_count, write_count, exp_cc, exp_wc);
        end
        if (exp_wc > 0) begin
            n_tests++;
            if (last_addr !== exp_la || last_data !== exp_ld) begin
                n_fail++;
                $display("FAIL %s last: addr=%h data=%h, required %h %h", tag, last_addr, last_data, exp_la, exp_ld);
            end
        end

        for (int k = 0; k < 3; k++) begin
            MemWrite     = noise;
            ALUresult    = MB;
            WriteDataMem = $urandom;
            tick();
            n_tests++;
            if (done !== 1'b1 || pass !== exp_pass || timeout !== exp_to ||
                cycle_count !== CW'(exp_cc) || write_count !== CW'(exp_wc)) begin
                n_fail++;
                $display("FAIL %s done-hold k=%0d: done=%b pass=%b to=%b cc=%0d wc=%0d, required 1 %b %b %0d %0d",
                         tag, k, done, pass, timeout, cycle_count, write_count, exp_pass, exp_to, exp_cc, exp_wc);
            end
        end
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            MemWrite     = $urandom_range(0, 1);
            ALUresult    = MB;
            WriteDataMem = PV;
            n_tests++;
            if (core_reset !== 1'b1 || done !== 1'b0 || running !== 1'b0 || cycle_count !== '0 ||
                write_count !== '0 || last_addr !== '0 || last_data !== '0) begin
                n_fail++;
                $display("FAIL reset-idle k=%0d: core_reset=%b done=%b running=%b cc=%0d wc=%0d la=%h ld=%h, required 1 0 0 0 0 0 0",
                         k, core_reset, done, running, cycle_count, write_count, last_addr, last_data);
            end
            tick();
        end
        MemWrite = 1'b0;
    endtask

    task automatic test_pass();
        clear_plan();
        pw[5]  = 1'b1; pa[5]  = 32'h10; pd[5]  = 32'hAA;
        pw[12] = 1'b1; pa[12] = 32'h20; pd[12] = 32'hBB;
        pw[30] = 1'b1; pa[30] = MB;     pd[30] = PV;
        run_check("pass", -1, 1'b0);
    endtask

    task automatic test_fail();
        clear_plan();
        pw[3]  = 1'b1; pa[3]  = 32'h40; pd[3]  = 32'h1234;
        pw[17] = 1'b1; pa[17] = MB;     pd[17] = 32'h5;
        run_check("fail", -1, 1'b0);
    endtask

    task automatic test_timeout();
        make_random(-1, 1'b0);
        run_check("timeout", -1, 1'b0);
    endtask

    task automatic test_hit_last();
        make_random(int'(MAXC) - 1, 1'b1);
        run_check("hit-last", -1, 1'b0);
    endtask

    task automatic test_boundary();
        make_random(40, 1'b1);
        run_check("start-in-run", 10, 1'b1);
    endtask

    task automatic test_back_to_back();
        make_random(20, 1'b0);
        run_check("b2b-1", -1, 1'b1);
        make_random(8, 1'b1);
        run_check("b2b-2", -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < int'(RSTC); k++) tick();
        for (int r = 0; r < 12; r++) begin
            MemWrite     = $urandom_range(0, 1);
            ALUresult    = other_addr();
            WriteDataMem = $urandom;
            tick();
        end
        reset        = 1'b1;
        MemWrite     = 1'b1;
        ALUresult    = MB;
        WriteDataMem = PV;
        tick();
        reset    = 1'b0;
        MemWrite = 1'b0;
        n_tests++;
        if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            cycle_count !== '0 || write_count !== '0 || last_addr !== '0 || last_data !== '0) begin
            n_fail++;
            $display("FAIL reset-mid: core_reset=%b running=%b done=%b pass=%b cc=%0d wc=%0d la=%h ld=%h, required 1 0 0 0 0 0 0 0",
                     core_reset, running, done, pass, cycle_count, write_count, last_addr, last_data);
        end
        tick();
        n_tests++;
        if (core_reset !== 1'b1 || running !== 1'b0 || cycle_count !== '0) begin
            n_fail++;
            $display("FAIL reset-mid-idle: core_reset=%b running=%b cc=%0d, required 1 0 0", core_reset, running, cycle_count);
        end
        make_random(25, 1'b1);
        run_check("after-reset", -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int h;
            h = $urandom_range(0, 60);
            make_random(h, $urandom_range(0, 1) == 1);
            run_check("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 49)) : -1,
                      $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_hit_last();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
